bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; ports named Clock and Reset.
REQ-002 Parameters SHALL be:
- WAIT_STATES, 0: minimum extra ACCESS cycles.
- TIMEOUT, 255: maximum nWait-low cycles before abort.
REQ-003 Ports SHALL be:
- Clock  in  1  system clock
- Reset  in  1  synchronous active-high reset
- CpuReq  in  1  CPU access request, level
- CpuWrite  in  1  CPU write (1) / read (0)
- CpuAddr  in  16  CPU address
- CpuWData  in  16  CPU write data
- CpuDone  out  1  CPU transaction complete, 1-cycle pulse
- DmaReq  in  1  DMA access request, level
- DmaWrite  in  1  DMA write / read
- DmaAddr  in  16  DMA address
- DmaWData  in  16  DMA write data
- DmaDone  out  1  DMA transaction complete, 1-cycle pulse
- RData  out  16  read data, valid while a Done is high
- BusErr  out  1  timeout flag, valid while a Done is high
- Data_out  out  16  multiplexed address/data to pads
- Data_in  in  16  data from pads
- ALE  out  1  address latch enable
- nME  out  1  memory enable, active low
- nOE  out  1  output enable, active low
- RnW  out  1  read-not-write
- ENB  out  1  pad output-driver enable
- nWait  in  1  memory wait, active low

Function
REQ-004 The FSM SHALL have states IDLE, ADDR, ACCESS and DONE; all outputs SHALL be registered.
REQ-005 In IDLE and DONE: ALE=0, nME=1, nOE=1, RnW=1, ENB=0, Data_out=0.
REQ-006 Arbitration SHALL occur only in IDLE:
- One Req high: grant it.
- Both high: grant the requester not granted last.
- First tie after reset goes to CPU.
REQ-007 On grant, the winner's Addr/WData/Write SHALL be latched; IDLE->ADDR. Later changes to the Req/Addr inputs SHALL be ignored until DONE.
REQ-008 ADDR SHALL last exactly 1 cycle: ALE=1, ENB=1, Data_out=latched address; then ->ACCESS.
REQ-009 In ACCESS: ALE=0, nME=0.
- Read: nOE=0, ENB=0.
- Write: RnW=0, ENB=1, Data_out=latched WData.
REQ-010 ACCESS SHALL last at least WAIT_STATES+1 cycles. After that minimum, it SHALL exit on the first cycle with nWait=1; nWait is ignored before the minimum elapses.
REQ-011 Read exit: Data_in sampled at the ACCESS->DONE edge SHALL appear on RData in DONE.
REQ-012 DONE SHALL last 1 cycle:
- The granted requester's Done=1.
- BusErr=1 only if aborted.
- DONE->IDLE.
REQ-013 Latency with WAIT_STATES=0 and nWait=1: Req seen in IDLE at cycle 0; Done high in cycle 3; earliest next grant in cycle 4.
REQ-014 A wait counter SHALL count nWait-low cycles after the minimum. At TIMEOUT it SHALL force ACCESS->DONE with BusErr=1 and RData=0.
REQ-015 A requester still holding Req in DONE SHALL be treated as a new request in IDLE, subject to round-robin.
REQ-016 RData and BusErr SHALL hold their value outside DONE; the two Done outputs SHALL never be high together.

Reset
REQ-017 Reset SHALL force, on the next edge and from any state:
- state=IDLE and all outputs to REQ-005 values.
- CpuDone=0, DmaDone=0, BusErr=0, RData=0.
- counters=0 and last-grant pointer=CPU.
- Any in-flight transaction is discarded with no Done.

Structure
REQ-018 Package bus_types SHALL hold:
- the bus_state_t enum (IDLE, ADDR, ACCESS, DONE).
- the requester_t enum (CPU, DMA).
REQ-019 Two-way round-robin grant logic SHALL be a sub-module rr_arbiter2 (Clock, Reset, two requests, update strobe, one-hot grant).

Verification
REQ-020 CPU read 0x1234, WAIT_STATES=0, Data_in=0xBEEF -> ALE high in cycle 1; nME=nOE=0 in cycle 2; CpuDone and RData=0xBEEF in cycle 3.
REQ-021 DMA write 0x00FF <- 0xA5A5 -> Data_out=0x00FF with ALE=1, then 0xA5A5 with RnW=0, ENB=1; DmaDone pulses once.
REQ-022 Both Req held high for four transactions -> grants alternate CPU, DMA, CPU, DMA; no overlapping Done.
REQ-023 nWait held low 3 cycles in ACCESS, WAIT_STATES=1 -> ACCESS lasts 4 cycles; Done follows nWait rising.
REQ-024 nWait held low with TIMEOUT=4 -> abort after 4 wait cycles; Done with BusErr=1 and RData=0.
REQ-025 Reset asserted in ACCESS -> next cycle IDLE, nME=1, no Done; first subsequent tie granted to CPU.

Source files
------------

// File: rtl/bus_types.sv
// Shared types for the CPU/DMA external bus arbiter.
package bus_types;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        ACCESS,
        DONE
    } bus_state_t;

    typedef enum logic {
        CPU = 1'b0,
        DMA = 1'b1
    } requester_t;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority advances on update.
module rr_arbiter2
    import bus_types::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Requester that wins the next tie; reset so the first tie goes to the CPU.
    requester_t prio_q;

    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = (prio_q == CPU) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            prio_q <= CPU;
        end else if (update && (grant != 2'b00)) begin
            prio_q <= grant[0] ? DMA : CPU;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates CPU and DMA onto a multiplexed address/data bus with wait states and timeout.
module bus_arbiter
    import bus_types::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CpuReq,
    input  logic        CpuWrite,
    input  logic [15:0] CpuAddr,
    input  logic [15:0] CpuWData,
    output logic        CpuDone,
    input  logic        DmaReq,
    input  logic        DmaWrite,
    input  logic [15:0] DmaAddr,
    input  logic [15:0] DmaWData,
    output logic        DmaDone,
    output logic [15:0] RData,
    output logic        BusErr,
    output logic [15:0] Data_out,
    input  logic [15:0] Data_in,
    output logic        ALE,
    output logic        nME,
    output logic        nOE,
    output logic        RnW,
    output logic        ENB,
    input  logic        nWait
);

    bus_state_t       state_q, state_d;
    requester_t       owner_q, owner_d;
    logic             write_q, write_d;
    logic [15:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, wait_cnt_q, wait_cnt_d;

    logic             ale_d, nme_d, noe_d, rnw_d, enb_d;
    logic             cpu_done_d, dma_done_d, bus_err_d;
    logic [15:0]      data_out_d, rdata_d;

    logic [1:0]       grant;
    logic             arb_update, min_done, finish, abort;

    rr_arbiter2 u_rr_arbiter2 (
        .Clock  (Clock),
        .Reset  (Reset),
        .req    ({DmaReq, CpuReq}),
        .update (arb_update),
        .grant  (grant)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        acc_cnt_d  = acc_cnt_q;
        wait_cnt_d = wait_cnt_q;
        arb_update = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        min_done   = 32'(acc_cnt_q) >= WAIT_STATES;

        ale_d      = 1'b0;
        nme_d      = 1'b1;
        noe_d      = 1'b1;
        rnw_d      = 1'b1;
        enb_d      = 1'b0;
        data_out_d = 16'h0000;
        cpu_done_d = 1'b0;
        dma_done_d = 1'b0;
        bus_err_d  = BusErr;
        rdata_d    = RData;

        unique case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    arb_update = 1'b1;
                    state_d    = ADDR;
                    acc_cnt_d  = '0;
                    wait_cnt_d = '0;
                    if (grant[0]) begin
                        owner_d = CPU;
                        write_d = CpuWrite;
                        addr_d  = CpuAddr;
                        wdata_d = CpuWData;
                    end else begin
                        owner_d = DMA;
                        write_d = DmaWrite;
                        addr_d  = DmaAddr;
                        wdata_d = DmaWData;
                    end
                end
            end
            ADDR: state_d = ACCESS;
            ACCESS: begin
                // nWait only matters once the minimum access time has elapsed.
                if (!min_done) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                end else if (nWait) begin
                    finish = 1'b1;
                end else if (32'(wait_cnt_q) + 32'd1 >= TIMEOUT) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
                if (finish) begin
                    state_d    = DONE;
                    cpu_done_d = (owner_q == CPU);
                    dma_done_d = (owner_q == DMA);
                    bus_err_d  = abort;
                    if (abort) begin
                        rdata_d = 16'h0000;
                    end else if (!write_q) begin
                        rdata_d = Data_in;
                    end
                end
            end
            DONE: state_d = IDLE;
        endcase

        // Pad outputs are registered, so decode them from the state being entered.
        case (state_d)
            ADDR: begin
                ale_d      = 1'b1;
                enb_d      = 1'b1;
                data_out_d = addr_d;
            end
            ACCESS: begin
                nme_d = 1'b0;
                if (write_d) begin
                    rnw_d      = 1'b0;
                    enb_d      = 1'b1;
                    data_out_d = wdata_d;
                end else begin
                    noe_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            owner_q    <= CPU;
            write_q    <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            acc_cnt_q  <= '0;
            wait_cnt_q <= '0;
            ALE        <= 1'b0;
            nME        <= 1'b1;
            nOE        <= 1'b1;
            RnW        <= 1'b1;
            ENB        <= 1'b0;
            Data_out   <= 16'h0000;
            CpuDone    <= 1'b0;
            DmaDone    <= 1'b0;
            BusErr     <= 1'b0;
            RData      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            acc_cnt_q  <= acc_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ALE        <= ale_d;
            nME        <= nme_d;
            nOE        <= noe_d;
            RnW        <= rnw_d;
            ENB        <= enb_d;
            Data_out   <= data_out_d;
            CpuDone    <= cpu_done_d;
            DmaDone    <= dma_done_d;
            BusErr     <= bus_err_d;
            RData      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: a driver predicts each transaction,
// a monitor checks the pads and Done/RData/BusErr as transactions complete.
module tb_bus_arbiter;
    import bus_types::*;

    localparam int WS = 1;
    localparam int TO = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        CpuReq = 1'b0, CpuWrite = 1'b0, DmaReq = 1'b0, DmaWrite = 1'b0;
    logic [15:0] CpuAddr = 16'h0, CpuWData = 16'h0, DmaAddr = 16'h0, DmaWData = 16'h0;
    logic [15:0] Data_in = 16'h0;
    logic        nWait = 1'b1;
    logic        CpuDone, DmaDone, BusErr, ALE, nME, nOE, RnW, ENB;
    logic [15:0] RData, Data_out;

    bus_arbiter #(
        .WAIT_STATES (WS),
        .TIMEOUT     (TO)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .CpuReq   (CpuReq),
        .CpuWrite (CpuWrite),
        .CpuAddr  (CpuAddr),
        .CpuWData (CpuWData),
        .CpuDone  (CpuDone),
        .DmaReq   (DmaReq),
        .DmaWrite (DmaWrite),
        .DmaAddr  (DmaAddr),
        .DmaWData (DmaWData),
        .DmaDone  (DmaDone),
        .RData    (RData),
        .BusErr   (BusErr),
        .Data_out (Data_out),
        .Data_in  (Data_in),
        .ALE      (ALE),
        .nME      (nME),
        .nOE      (nOE),
        .RnW      (RnW),
        .ENB      (ENB),
        .nWait    (nWait)
    );

    initial forever #5 Clock = ~Clock;

    typedef struct {
        requester_t  who;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        int          len;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    requester_t prio_m = CPU;
    int         cur_low = 0;
    int         run_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Memory model for nWait: low for the first cur_low ACCESS cycles, random elsewhere.
    initial forever begin
        @(posedge Clock);
        #1;
        if (!nME) begin
            nWait = (run_cnt >= cur_low);
            run_cnt++;
        end else begin
            run_cnt = 0;
            nWait = 1'($urandom);
        end
    end

    task automatic scramble();
        CpuReq   = 1'($urandom);
        CpuWrite = 1'($urandom);
        CpuAddr  = 16'($urandom);
        CpuWData = 16'($urandom);
        DmaReq   = 1'($urandom);
        DmaWrite = 1'($urandom);
        DmaAddr  = 16'($urandom);
        DmaWData = 16'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            CpuReq  = 1'b0;
            DmaReq  = 1'b0;
            Data_in = 16'($urandom);
        end
    endtask

    // Present requests in an IDLE cycle, predict the outcome, then keep the bus busy.
    task automatic do_txn(input logic creq, input logic dreq,
                          input logic cw, input logic [15:0] ca, input logic [15:0] cwd,
                          input logic dw, input logic [15:0] da, input logic [15:0] dwd,
                          input int low, input logic [15:0] din);
        exp_t e;
        int   w;
        @(negedge Clock);
        CpuReq = creq; CpuWrite = cw; CpuAddr = ca; CpuWData = cwd;
        DmaReq = dreq; DmaWrite = dw; DmaAddr = da; DmaWData = dwd;
        Data_in = 16'($urandom);
        cur_low = low;
        e.who   = (creq && dreq) ? prio_m : (creq ? CPU : DMA);
        prio_m  = (e.who == CPU) ? DMA : CPU;
        e.wr    = (e.who == CPU) ? cw : dw;
        e.addr  = (e.who == CPU) ? ca : da;
        e.wdata = (e.who == CPU) ? cwd : dwd;
        w       = (low > WS) ? low - WS : 0;
        e.err   = (w >= TO);
        e.len   = e.err ? WS + TO : WS + w + 1;
        e.rdata = e.err ? 16'h0 : din;
        q.push_back(e);
        for (int i = 1; i <= 2 + e.len; i++) begin
            @(negedge Clock);
            scramble();
            Data_in = (i == 1 + e.len) ? din : 16'($urandom);
        end
    endtask

    // Monitor: collects the pad activity of each transaction and scores it on Done.
    logic        prev_done = 1'b0;
    int          ale_cnt = 0, acc_cnt = 0;
    logic        acc_var = 1'b0;
    logic [15:0] addr_seen = 16'h0, acc_dout = 16'h0;
    logic [3:0]  ale_pads = 4'h0, acc_pads = 4'h0;

    initial forever begin
        @(posedge Clock);
        #1;
        if (Reset) begin
            prev_done = 1'b0;
            ale_cnt = 0; acc_cnt = 0; acc_var = 1'b0;
        end else begin
            if (prev_done) check("done_pulse", 32'({CpuDone, DmaDone}), 32'h0);
            prev_done = CpuDone || DmaDone;
            if (ALE) begin
                ale_cnt++;
                addr_seen = Data_out;
                ale_pads  = {ENB, nME, nOE, RnW};
            end
            if (!nME) begin
                if (acc_cnt == 0) begin
                    acc_pads = {ALE, RnW, ENB, nOE};
                    acc_dout = Data_out;
                end else if ({ALE, RnW, ENB, nOE} != acc_pads || Data_out != acc_dout) begin
                    acc_var = 1'b1;
                end
                acc_cnt++;
            end
            if (CpuDone || DmaDone) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'({CpuDone, DmaDone}), 32'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_id", 32'({CpuDone, DmaDone}), (e.who == CPU) ? 32'h2 : 32'h1);
                    check("bus_err", 32'(BusErr), 32'(e.err));
                    if (!e.wr || e.err) check("rdata", 32'(RData), 32'(e.rdata));
                    check("addr_phase", {12'h0, 4'(ale_cnt), ale_pads, addr_seen},
                          {12'h0, 4'd1, 4'b1111, e.addr});
                    check("access_len", 32'(acc_cnt), 32'(e.len));
                    if (e.wr)
                        check("write_pads", {11'h0, acc_var, acc_pads, acc_dout},
                              {11'h0, 1'b0, 4'b0011, e.wdata});
                    else
                        check("read_pads", {27'h0, acc_var, acc_pads}, {27'h0, 1'b0, 4'b0100});
                    check("done_pads", {10'h0, ALE, nME, nOE, RnW, ENB, 1'b0, Data_out},
                          {10'h0, 5'b01110, 1'b0, 16'h0});
                end
                ale_cnt = 0; acc_cnt = 0; acc_var = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge Clock);
        check("reset_pads", {23'h0, ALE, nME, nOE, RnW, ENB, CpuDone, DmaDone, BusErr, 1'b0},
              {23'h0, 8'b0111_0000, 1'b0});
        check("reset_data", {RData, Data_out}, 32'h0);
        Reset = 1'b0;
        prio_m = CPU;

        do_txn(1, 0, 0, 16'h1234, 16'h0, 0, 16'h0, 16'h0, 0, 16'hBEEF);
        do_txn(0, 1, 0, 16'h0, 16'h0, 1, 16'h00FF, 16'hA5A5, 0, 16'h0);
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, 1'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom), 16'($urandom), 16'($urandom), 0, 16'($urandom));
        do_txn(1, 0, 0, 16'h4000, 16'h0, 0, 16'h0, 16'h0, 3, 16'h5A5A);
        do_txn(0, 1, 0, 16'h0, 16'h0, 0, 16'h8000, 16'h0, 8, 16'hFFFF);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(1, 3);
            do_txn(r[0], r[1], 1'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom), 16'($urandom), 16'($urandom),
                   $urandom_range(0, 6), 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // Reset in the middle of ACCESS discards the transaction.
        do_txn(1, 0, 0, 16'h0042, 16'h0, 0, 16'h0, 16'h0, 0, 16'hBEEF);
        @(negedge Clock);
        CpuReq = 1'b1; DmaReq = 1'b1; CpuWrite = 1'b0; DmaWrite = 1'b1;
        CpuAddr = 16'h1111; DmaAddr = 16'h2222;
        cur_low = 10;
        @(negedge Clock);
        CpuReq = 1'b0; DmaReq = 1'b0;
        @(negedge Clock);
        check("pre_reset_access", 32'(nME), 32'h0);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("mid_reset_pads", {23'h0, ALE, nME, nOE, RnW, ENB, CpuDone, DmaDone, BusErr, 1'b0},
              {23'h0, 8'b0111_0000, 1'b0});
        check("mid_reset_data", {RData, Data_out}, 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        prio_m = CPU;
        idle(4);
        do_txn(1, 1, 0, 16'hAAAA, 16'h0, 0, 16'hBBBB, 16'h0, 0, 16'h1357);
        do_txn(1, 1, 1, 16'hCCCC, 16'h9999, 1, 16'hDDDD, 16'h7777, 2, 16'h0);

        idle(12);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
